// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel,
// decoder-side instruction handshake and the execute redirect port.
interface instruction_fetch_if;
    // instruction memory request channel
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    // instruction memory response channel (in order, never back-pressured)
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    // decoder handshake
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    // control-flow redirect from execute
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // fetch unit side
    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
               redirect_valid, redirect_pc
    );

    // memory / decoder / execute side
    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: credit-limited in-order request stream to
// instruction memory, FIFO_DEPTH-entry instruction buffer toward the decoder,
// and redirect handling that discards responses of stale requests.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    instruction_fetch_if.master   bus
);
    localparam int PW = $clog2(FIFO_DEPTH);  // pointer width
    localparam int CW = PW + 1;              // counter width, holds 0..FIFO_DEPTH
    localparam int SW = CW + 1;              // width of count + outstanding

    typedef enum logic {
        ST_RESET,
        ST_FETCH
    } state_e;

    state_e                       state_q, state_d;
    logic [31:0]                  fetch_pc_q, fetch_pc_d;
    logic [31:0]                  resp_pc_q, resp_pc_d;
    logic [CW-1:0]                outstanding_q, outstanding_d;
    logic [CW-1:0]                drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]                count_q, count_d;
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH-1:0][31:0]  buf_data_q;
    logic [FIFO_DEPTH-1:0][31:0]  buf_pc_q;

    logic        in_fetch;
    logic        redirect;
    logic [SW-1:0] credit_used;
    logic        req_valid;
    logic        req_fire;
    logic        rsp_keep;
    logic        pop;
    logic        inst_valid;
    logic [31:0] redirect_pc_aligned;

    assign in_fetch            = (state_q == ST_FETCH);
    // Redirects are only honoured once fetching has started.
    assign redirect            = in_fetch && bus.redirect_valid;
    assign redirect_pc_aligned = bus.redirect_pc & ~32'h3;

    // Buffered plus in-flight words may never exceed the buffer size, so
    // every response has a guaranteed slot.
    assign credit_used = {1'b0, count_q} + {1'b0, outstanding_q};
    assign req_valid   = in_fetch && !bus.redirect_valid &&
                         (credit_used < SW'(FIFO_DEPTH));
    assign req_fire    = req_valid && bus.imem_req_ready;

    // Responses are dropped while stale ones remain, or when they land in
    // the redirect cycle itself.
    assign rsp_keep    = bus.imem_rsp_valid && !redirect && (drop_cnt_q == '0);

    assign inst_valid  = (count_q != '0);
    assign pop         = inst_valid && bus.inst_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.inst_valid     = inst_valid;
    assign bus.inst_data      = inst_valid ? buf_data_q[rd_ptr_q] : 32'h0;
    assign bus.inst_pc        = inst_valid ? buf_pc_q[rd_ptr_q]   : 32'h0;

    // FSM next state: RESET lasts one cycle after rst drops, then FETCH forever.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: state_d = ST_FETCH;
            default:  state_d = ST_RESET;
        endcase
    end

    // Datapath next state: PCs, credit/drop counters and buffer pointers.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (redirect) begin
            // outstanding counts every request still in flight (stale ones
            // included), so all of them except one answering right now
            // become stale; this keeps back-to-back redirects exact.
            fetch_pc_d = redirect_pc_aligned;
            resp_pc_d  = redirect_pc_aligned;
            drop_cnt_d = outstanding_q - CW'(bus.imem_rsp_valid);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (req_fire)
                fetch_pc_d = fetch_pc_q + 32'd4;
            if (bus.imem_rsp_valid && (drop_cnt_q != '0))
                drop_cnt_d = drop_cnt_q - CW'(1);
            if (rsp_keep) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + PW'(1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(rsp_keep) - CW'(pop);
        end
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RESET;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Buffer storage; contents are masked at the outputs while empty, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && rsp_keep) begin
            buf_data_q[wr_ptr_q] <= bus.imem_rsp_data;
            buf_pc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

    // Credits make a response into a full buffer impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(bus.imem_rsp_valid && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory model with fixed latency, directed
// scenarios and a randomized run, all checked by a program-order scoreboard.
module tb_instruction_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_if bus();

    instruction_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nchk  = 0;
    int nfail = 0;
    int nfire = 0;
    int ndeliv = 0;
    logic [31:0] fire_log[$];
    logic [31:0] deliv_log[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_req = RST_PC;

    // Memory contents: a bijective scramble of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'hC001_D00D;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t pipe[$];
    int lat      = 1;
    int rdy_mode = 0;   // 0 always ready, 1 random, 2 never
    int cyc      = 0;

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        forever begin
            @(posedge clk); #2;
            cyc++;
            if (rst) begin
                pipe.delete();
                bus.imem_rsp_valid = 1'b0;
            end else if (pipe.size() > 0 && pipe[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = memf(pipe[0].addr);
                void'(pipe.pop_front());
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = $urandom;
            end
            case (rdy_mode)
                0:       bus.imem_req_ready = 1'b1;
                1:       bus.imem_req_ready = ($urandom_range(0, 3) != 0);
                default: bus.imem_req_ready = 1'b0;
            endcase
            @(negedge clk);
            if (!rst && bus.imem_req_valid && bus.imem_req_ready)
                pipe.push_back('{bus.imem_req_addr, cyc + lat});
        end
    end

    // ---------------- scoreboard monitor ----------------
    // Expected stream: consecutive word PCs from RESET_PC or the last redirect.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc, prev_data;

    initial begin
        exp_q.push_back(RST_PC);
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                exp_q.push_back(RST_PC);
                exp_req   = RST_PC;
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check1 ("hold_valid", bus.inst_valid, 1'b1);
                    check32("hold_pc",    bus.inst_pc,   prev_pc);
                    check32("hold_data",  bus.inst_data, prev_data);
                end
                if (bus.redirect_valid)
                    check1("req_blocked_on_redirect", bus.imem_req_valid, 1'b0);
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    check32("req_addr", bus.imem_req_addr, exp_req);
                    exp_req = exp_req + 32'd4;
                    nfire++;
                    fire_log.push_back(bus.imem_req_addr);
                end
                if (bus.inst_valid && bus.inst_ready) begin
                    logic [31:0] p;
                    p = exp_q.pop_front();
                    if (exp_q.size() == 0) exp_q.push_back(p + 32'd4);
                    check32("inst_pc",   bus.inst_pc,   p);
                    check32("inst_data", bus.inst_data, memf(p));
                    ndeliv++;
                    deliv_log.push_back(bus.inst_pc);
                end
                if (bus.redirect_valid) begin
                    exp_q.delete();
                    exp_q.push_back(bus.redirect_pc & ~32'h3);
                    exp_req = bus.redirect_pc & ~32'h3;
                end
                prev_hold = bus.inst_valid && !bus.inst_ready && !bus.redirect_valid;
                prev_pc   = bus.inst_pc;
                prev_data = bus.inst_data;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic wait_inst_valid(input string name);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.inst_valid) break;
        end
        check1(name, bus.inst_valid, 1'b1);
    endtask

    initial begin
        int n0, d0, nf;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // 1: reset values and first requests
        rst = 1'b1; lat = 1; rdy_mode = 0;
        step(); step();
        @(negedge clk);
        check1 ("rst_inst_valid", bus.inst_valid,     1'b0);
        check1 ("rst_req_valid",  bus.imem_req_valid, 1'b0);
        check32("rst_inst_pc",    bus.inst_pc,        32'h0);
        check32("rst_inst_data",  bus.inst_data,      32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check1("no_req_cycle1", bus.imem_req_valid, 1'b0);
        step();
        @(negedge clk);
        check1 ("first_req_valid", bus.imem_req_valid, 1'b1);
        check32("first_req_addr",  bus.imem_req_addr,  RST_PC);
        d0 = ndeliv;
        repeat (10) step();
        check1("t1_deliveries", (ndeliv - d0) >= 6, 1'b1);

        // 2: backpressure limits requests to the buffer size
        bus.inst_ready = 1'b0;
        do_reset(2);
        n0 = nfire;
        repeat (12) step();
        check32("bp_fire_count", 32'(nfire - n0), 32'd4);
        check32("bp_last_addr",  fire_log[$],     32'hC);
        @(negedge clk);
        check1 ("bp_req_stalled", bus.imem_req_valid, 1'b0);
        check1 ("bp_inst_valid",  bus.inst_valid,     1'b1);
        check32("bp_inst_pc",     bus.inst_pc,        32'h0);
        step();
        bus.inst_ready = 1'b1;
        d0 = ndeliv;
        repeat (10) step();
        check1("bp_resumed",  (nfire - n0) >= 6, 1'b1);
        check1("bp_released", (ndeliv - d0) >= 4, 1'b1);

        // 3: redirect with two stale responses in flight
        lat = 3;
        do_reset(2);
        n0 = nfire;
        for (int k = 0; k < 30; k++) begin
            if (nfire >= n0 + 2) break;
            @(posedge clk);
        end
        rdy_mode = 2;
        check32("t3_two_outstanding", 32'(nfire - n0), 32'd2);
        #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        rdy_mode = 0;
        wait_inst_valid("t3_valid_timeout");
        check32("t3_pc",   bus.inst_pc,   32'h100);
        check32("t3_data", bus.inst_data, memf(32'h100));

        // 4: redirect together with a decoder handshake
        lat = 1;
        bus.inst_ready = 1'b0;
        do_reset(2);
        repeat (10) step();
        rdy_mode = 2;
        bus.inst_ready = 1'b1;
        d0 = ndeliv;
        step(); step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        step();
        bus.redirect_valid = 1'b0;
        rdy_mode = 0;
        check32("t4_delivered", 32'(ndeliv - d0), 32'd3);
        check32("t4_last_pc",   deliv_log[$],     32'h8);
        wait_inst_valid("t4_valid_timeout");
        check32("t4_next_pc", bus.inst_pc, 32'h40);

        // 5: misaligned redirect and address wrap
        lat = 2;
        do_reset(2);
        repeat (3) step();
        nf = fire_log.size();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFF;
        step();
        bus.redirect_valid = 1'b0;
        repeat (8) step();
        check1("t5_fires", fire_log.size() >= nf + 2, 1'b1);
        if (fire_log.size() >= nf + 2) begin
            check32("t5_addr0", fire_log[nf],     32'hFFFF_FFFC);
            check32("t5_addr1", fire_log[nf + 1], 32'h0000_0000);
        end

        // 6: reset while three instructions are buffered
        lat = 1;
        bus.inst_ready = 1'b0;
        do_reset(2);
        n0 = nfire;
        for (int k = 0; k < 30; k++) begin
            if (nfire >= n0 + 3) break;
            @(posedge clk);
        end
        rdy_mode = 2;
        #1;
        repeat (3) step();
        @(negedge clk);
        check1 ("t6_buffered", bus.inst_valid, 1'b1);
        check32("t6_head_pc",  bus.inst_pc,    32'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check1 ("t6_inst_valid", bus.inst_valid,     1'b0);
        check1 ("t6_req_valid",  bus.imem_req_valid, 1'b0);
        check32("t6_inst_pc",    bus.inst_pc,        32'h0);
        step();
        rdy_mode = 0;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        check1 ("t6_restart_valid", bus.imem_req_valid, 1'b1);
        check32("t6_restart_addr",  bus.imem_req_addr,  RST_PC);

        // 7: randomized traffic, redirects and backpressure
        for (int r = 0; r < 3; r++) begin
            lat = $urandom_range(1, 4);
            do_reset(2);
            step();
            d0 = ndeliv;
            rdy_mode = 1;
            for (int i = 0; i < 600; i++) begin
                bus.inst_ready     = ($urandom_range(0, 3) != 0);
                bus.redirect_valid = ($urandom_range(0, 15) == 0);
                bus.redirect_pc    = $urandom;
                step();
            end
            bus.redirect_valid = 1'b0;
            check1("rand_progress", (ndeliv - d0) > 50, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
